paint_scheduler: RTL and testbench

PAINT_SCHEDULER -- requirements
Module: paint_scheduler

---
 rtl/paint_scheduler_pkg.sv | 21 ++
 rtl/paint_scheduler_clear_scanner.sv | 40 ++++
 rtl/paint_scheduler.sv | 173 +++++++++++++++++
 tb/tb_paint_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_scheduler_pkg.sv
// Shared types and frame constants for the paint scheduler.
package paint_scheduler_pkg;

    localparam int unsigned COOR_W       = 12;
    localparam int unsigned FRAME_WIDTH  = 1280;
    localparam int unsigned FRAME_HEIGHT = 300;

    typedef struct packed {
        logic        [COOR_W-1:0] sprite_x;
        logic        [COOR_W-1:0] sprite_y;
        logic signed [COOR_W-1:0] frame_x;
        logic signed [COOR_W-1:0] frame_y;
        logic        [COOR_W-1:0] width;
        logic        [COOR_W-1:0] height;
    } element_desc_t;

    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH, LOAD, START, PAINT, NEXT, DONE
    } state_t;

endpackage

// File: rtl/paint_scheduler_clear_scanner.sv
// Raster counter for the frame clear: x is the inner loop, y the outer.
module clear_scanner
    import paint_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH  = paint_scheduler_pkg::FRAME_WIDTH,
    parameter int unsigned HEIGHT = paint_scheduler_pkg::FRAME_HEIGHT,
    parameter int unsigned XW     = 11,
    parameter int unsigned YW     = 9
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic x_end;
    logic y_end;

    assign x_end = (x == XW'(WIDTH - 1));
    assign y_end = (y == YW'(HEIGHT - 1));
    assign last  = x_end && y_end;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/paint_scheduler.sv
// Frame render sequencer: optional clear, then walks the descriptor table driving the element painter.
module paint_scheduler
    import paint_scheduler_pkg::*;
#(
    parameter int unsigned COOR_WIDTH   = 12,
    parameter int unsigned FRAME_WIDTH  = paint_scheduler_pkg::FRAME_WIDTH,
    parameter int unsigned FRAME_HEIGHT = paint_scheduler_pkg::FRAME_HEIGHT,
    parameter int unsigned MAX_ELEMENTS = 32,
    parameter int unsigned IDX_WIDTH    = 5
)(
    input  logic                         clk_33m,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic                         clear_en,
    input  logic [IDX_WIDTH:0]           elem_count,
    output logic [IDX_WIDTH-1:0]         desc_addr,
    input  element_desc_t                desc_data,
    output logic                         pe_rst,
    output logic [COOR_WIDTH-1:0]        pe_sprite_x,
    output logic [COOR_WIDTH-1:0]        pe_sprite_y,
    output logic signed [COOR_WIDTH-1:0] pe_frame_x,
    output logic signed [COOR_WIDTH-1:0] pe_frame_y,
    output logic [COOR_WIDTH-1:0]        pe_width,
    output logic [COOR_WIDTH-1:0]        pe_height,
    input  logic [COOR_WIDTH-1:0]        pe_write_x,
    input  logic [COOR_WIDTH-1:0]        pe_write_y,
    input  logic [1:0]                   pe_write_palette,
    input  logic                         pe_finished,
    output logic                         fb_we,
    output logic [COOR_WIDTH-1:0]        fb_x,
    output logic [COOR_WIDTH-1:0]        fb_y,
    output logic [1:0]                   fb_palette,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int unsigned CNT_W = IDX_WIDTH + 1;
    localparam int unsigned XW    = $clog2(FRAME_WIDTH);
    localparam int unsigned YW    = $clog2(FRAME_HEIGHT);

    state_t                  state;
    state_t                  state_next;
    logic [IDX_WIDTH-1:0]    index;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_sat;
    logic                    paint_first;
    logic                    accept;
    logic                    zero_size;
    logic                    more;
    logic                    scan_start;
    logic                    scan_adv;
    logic                    scan_last;
    logic [XW-1:0]           scan_x;
    logic [YW-1:0]           scan_y;
    logic                    pe_rst_d;
    logic                    fb_we_d;
    logic [COOR_WIDTH-1:0]   fb_x_d;
    logic [COOR_WIDTH-1:0]   fb_y_d;
    logic [1:0]              fb_pal_d;

    assign count_sat = (elem_count > CNT_W'(MAX_ELEMENTS)) ? CNT_W'(MAX_ELEMENTS) : elem_count;
    assign accept    = (state == IDLE) && frame_start;
    assign zero_size = (desc_data.width == '0) || (desc_data.height == '0);
    assign more      = (CNT_W'(index) + CNT_W'(1)) < count_q;
    assign desc_addr = index;

    clear_scanner #(
        .WIDTH  (FRAME_WIDTH),
        .HEIGHT (FRAME_HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_clear_scanner (
        .clk     (clk_33m),
        .rst     (rst),
        .start   (scan_start),
        .advance (scan_adv),
        .x       (scan_x),
        .y       (scan_y),
        .last    (scan_last)
    );

    always_ff @(posedge clk_33m) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    if (clear_en)             state_next = CLEAR;
                    else if (count_sat != '0) state_next = FETCH;
                    else                      state_next = DONE;
                end
            end
            CLEAR:   if (scan_last) state_next = (count_q != '0) ? FETCH : DONE;
            FETCH:   state_next = LOAD;
            LOAD:    state_next = zero_size ? NEXT : START;
            START:   state_next = PAINT;
            // First PAINT cycle may still see the previous element's finished flag
            PAINT:   if (!paint_first && pe_finished) state_next = NEXT;
            NEXT:    state_next = more ? FETCH : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        scan_start = accept;
        scan_adv   = (state == CLEAR);
        pe_rst_d   = (state_next != PAINT);
        fb_we_d    = 1'b0;
        fb_x_d     = pe_write_x;
        fb_y_d     = pe_write_y;
        fb_pal_d   = pe_write_palette;
        if (state == CLEAR) begin
            fb_we_d  = 1'b1;
            fb_x_d   = COOR_WIDTH'(scan_x);
            fb_y_d   = COOR_WIDTH'(scan_y);
            fb_pal_d = 2'd0;
        end else if (state == PAINT && !paint_first) begin
            fb_we_d  = (pe_write_palette != 2'd0);
        end
    end

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            index       <= '0;
            count_q     <= '0;
            paint_first <= 1'b0;
            pe_rst      <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            fb_we       <= 1'b0;
            fb_x        <= '0;
            fb_y        <= '0;
            fb_palette  <= '0;
            pe_sprite_x <= '0;
            pe_sprite_y <= '0;
            pe_frame_x  <= '0;
            pe_frame_y  <= '0;
            pe_width    <= '0;
            pe_height   <= '0;
        end else begin
            pe_rst      <= pe_rst_d;
            busy        <= (state_next != IDLE);
            frame_done  <= (state_next == DONE);
            fb_we       <= fb_we_d;
            paint_first <= (state == START);
            if (fb_we_d) begin
                fb_x       <= fb_x_d;
                fb_y       <= fb_y_d;
                fb_palette <= fb_pal_d;
            end
            if (accept) begin
                index   <= '0;
                count_q <= count_sat;
            end else if (state == NEXT && more) begin
                index <= index + IDX_WIDTH'(1);
            end
            if (state == LOAD) begin
                pe_sprite_x <= COOR_WIDTH'(desc_data.sprite_x);
                pe_sprite_y <= COOR_WIDTH'(desc_data.sprite_y);
                pe_frame_x  <= COOR_WIDTH'(desc_data.frame_x);
                pe_frame_y  <= COOR_WIDTH'(desc_data.frame_y);
                pe_width    <= COOR_WIDTH'(desc_data.width);
                pe_height   <= COOR_WIDTH'(desc_data.height);
            end
        end
    end

endmodule

// File: tb/tb_paint_scheduler.sv
// Self-checking bench for paint_scheduler: descriptor RAM, painter model and frame-level scoreboard.
module tb_paint_scheduler;
    import paint_scheduler_pkg::*;

    localparam int unsigned CW = 12;
    localparam int unsigned FW = 40;
    localparam int unsigned FH = 12;
    localparam int unsigned ME = 32;
    localparam int unsigned IW = 5;

    logic                 clk_33m = 1'b0;
    logic                 rst = 1'b1;
    logic                 frame_start = 1'b0;
    logic                 clear_en = 1'b0;
    logic [IW:0]          elem_count = '0;
    logic [IW-1:0]        desc_addr;
    element_desc_t        desc_data = '0;
    logic                 pe_rst;
    logic [CW-1:0]        pe_sprite_x, pe_sprite_y, pe_width, pe_height;
    logic signed [CW-1:0] pe_frame_x, pe_frame_y;
    logic [CW-1:0]        pe_write_x = '0;
    logic [CW-1:0]        pe_write_y = '0;
    logic [1:0]           pe_write_palette = '0;
    logic                 pe_finished = 1'b0;
    logic                 fb_we;
    logic [CW-1:0]        fb_x, fb_y;
    logic [1:0]           fb_palette;
    logic                 busy, frame_done;

    paint_scheduler #(
        .COOR_WIDTH(CW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
        .MAX_ELEMENTS(ME), .IDX_WIDTH(IW)
    ) dut (
        .clk_33m(clk_33m), .rst(rst), .frame_start(frame_start), .clear_en(clear_en),
        .elem_count(elem_count), .desc_addr(desc_addr), .desc_data(desc_data),
        .pe_rst(pe_rst), .pe_sprite_x(pe_sprite_x), .pe_sprite_y(pe_sprite_y),
        .pe_frame_x(pe_frame_x), .pe_frame_y(pe_frame_y), .pe_width(pe_width),
        .pe_height(pe_height), .pe_write_x(pe_write_x), .pe_write_y(pe_write_y),
        .pe_write_palette(pe_write_palette), .pe_finished(pe_finished),
        .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_palette(fb_palette),
        .busy(busy), .frame_done(frame_done)
    );

    always #15 clk_33m = ~clk_33m;

    typedef struct { logic [CW-1:0] x; logic [CW-1:0] y; logic [1:0] p; } wr_t;
    typedef struct { logic ce; int cnt; logic [31:0] zmask; int exp_starts; int exp_clear; } vec_t;

    element_desc_t desc_mem [ME];
    int            pm_mode = 0;
    int unsigned   pm_k = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    // Registered descriptor RAM: data valid one cycle after the address
    always @(posedge clk_33m) desc_data <= desc_mem[desc_addr];

    function automatic logic [1:0] pix_pal(int unsigned k);
        return (pm_mode != 0) ? 2'(k % 4) : 2'(k % 3 + 1);
    endfunction

    // Painter: one pixel per cycle once released; finished stays stale while held in reset
    always @(posedge clk_33m) begin
        if (pe_rst) begin
            pm_k             <= 0;
            pe_write_palette <= '0;
        end else if (pm_k < 32'(pe_width) * 32'(pe_height)) begin
            pe_write_x       <= pe_frame_x + CW'(pm_k % 32'(pe_width));
            pe_write_y       <= pe_frame_y + CW'(pm_k / 32'(pe_width));
            pe_write_palette <= pix_pal(pm_k);
            pe_finished      <= 1'b0;
            pm_k             <= pm_k + 1;
        end else begin
            pe_write_palette <= '0;
            pe_finished      <= 1'b1;
        end
    end

    wr_t           got_q[$];
    wr_t           exp_q[$];
    int            addr_q[$];
    int            n_done = 0, n_starts = 0, n_clear = 0, clr_bad = 0;
    int            neg_cyc = 0, fs_neg = 0, first_clr_neg = 0;
    logic          clr_seen = 1'b0;
    logic [CW-1:0] cx = '0, cy = '0, last_cx = '0, last_cy = '0;
    logic          prev_pe_rst = 1'b1, prev_busy = 1'b0;
    logic [IW-1:0] prev_addr = '0;

    always @(negedge clk_33m) begin
        neg_cyc <= neg_cyc + 1;
        if (frame_start && !busy && !rst) begin
            fs_neg   <= neg_cyc;
            cx       <= '0;
            cy       <= '0;
            clr_seen <= 1'b0;
        end
        if (fb_we) begin
            if (fb_palette == 2'd0) begin
                if (!clr_seen) first_clr_neg <= neg_cyc;
                clr_seen <= 1'b1;
                if (fb_x != cx || fb_y != cy) clr_bad <= clr_bad + 1;
                last_cx <= fb_x;
                last_cy <= fb_y;
                n_clear <= n_clear + 1;
                if (cx == CW'(FW - 1)) begin
                    cx <= '0;
                    cy <= (cy == CW'(FH - 1)) ? '0 : cy + CW'(1);
                end else begin
                    cx <= cx + CW'(1);
                end
            end else begin
                got_q.push_back('{fb_x, fb_y, fb_palette});
            end
        end
        if (frame_done) n_done <= n_done + 1;
        if (prev_pe_rst && !pe_rst) n_starts <= n_starts + 1;
        if (busy && (!prev_busy || desc_addr != prev_addr)) addr_q.push_back(int'(desc_addr));
        prev_pe_rst <= pe_rst;
        prev_busy   <= busy;
        prev_addr   <= desc_addr;
    end

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_desc(logic [31:0] zmask);
        for (int i = 0; i < int'(ME); i++) begin
            element_desc_t d;
            d.sprite_x = CW'($urandom_range(0, 100));
            d.sprite_y = CW'($urandom_range(0, 100));
            d.frame_x  = CW'(int'($urandom_range(0, 60)) - 8);
            d.frame_y  = CW'(int'($urandom_range(0, 30)) - 4);
            d.width    = CW'($urandom_range(1, 4));
            d.height   = CW'($urandom_range(1, 4));
            if (zmask[i]) begin
                if (i % 2 == 1) d.width = '0;
                else            d.height = '0;
            end
            desc_mem[i] = d;
        end
    endtask

    // Reference: every non-empty element paints its w*h raster row by row, transparent pixels dropped
    task automatic build_expected(int cnt);
        int n;
        n = (cnt > int'(ME)) ? int'(ME) : cnt;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            element_desc_t d;
            d = desc_mem[i];
            for (int unsigned k = 0; k < 32'(d.width) * 32'(d.height); k++) begin
                logic [1:0] p;
                p = pix_pal(k);
                if (p != 2'd0)
                    exp_q.push_back('{d.frame_x + CW'(k % 32'(d.width)),
                                      d.frame_y + CW'(k / 32'(d.width)), p});
            end
        end
    endtask

    task automatic run_frame(string tag, logic ce, int cnt, int exp_starts, int exp_clear,
                             bit extra, output int n_wr);
        int d0, s0, c0, b0, g0, a0, c, mism, na, n;
        d0 = n_done; s0 = n_starts; c0 = n_clear; b0 = clr_bad;
        g0 = got_q.size(); a0 = addr_q.size();
        build_expected(cnt);
        @(posedge clk_33m); #1;
        frame_start = 1'b1; clear_en = ce; elem_count = (IW + 1)'(cnt);
        @(posedge clk_33m); #1;
        frame_start = 1'b0;
        if (extra) begin
            c = 0;
            while (pe_rst && c < 2000) begin @(posedge clk_33m); #1; c++; end
            check({tag, " paint reached"}, longint'(c >= 2000), 0);
            frame_start = 1'b1; clear_en = 1'b1; elem_count = '0;
            @(posedge clk_33m); #1;
            frame_start = 1'b0;
        end
        c = 0;
        while (n_done == d0 && c < 5000) begin @(posedge clk_33m); c++; end
        check({tag, " done timeout"}, longint'(c >= 5000), 0);
        repeat (6) @(posedge clk_33m);
        #1;
        check({tag, " frame_done count"}, n_done - d0, 1);
        check({tag, " busy after"}, busy, 0);
        check({tag, " starts"}, n_starts - s0, exp_starts);
        check({tag, " clear writes"}, n_clear - c0, exp_clear);
        if (exp_clear > 0) begin
            check({tag, " clear order errs"}, clr_bad - b0, 0);
            check({tag, " first clear latency"}, first_clr_neg - fs_neg, 2);
            check({tag, " last clear x"}, last_cx, FW - 1);
            check({tag, " last clear y"}, last_cy, FH - 1);
        end
        n_wr = got_q.size() - g0;
        mism = 0;
        if (n_wr != exp_q.size()) mism++;
        else for (int i = 0; i < n_wr; i++)
            if (got_q[g0 + i] != exp_q[i]) mism++;
        check({tag, " pixel writes vs model"}, mism, 0);
        n = (cnt > int'(ME)) ? int'(ME) : cnt;
        na = (n == 0) ? 1 : n;
        mism = 0;
        if (addr_q.size() - a0 != na) mism++;
        else for (int i = 0; i < na; i++)
            if (addr_q[a0 + i] != i) mism++;
        check({tag, " desc_addr sequence"}, mism, 0);
    endtask

    vec_t vecs[8];

    initial begin
        int nw, d0, c;
        vecs[0] = '{1'b1, 0,  32'h0,         0,  int'(FW * FH)};
        vecs[1] = '{1'b0, 3,  32'h2,         2,  0};
        vecs[2] = '{1'b0, 0,  32'h0,         0,  0};
        vecs[3] = '{1'b1, 2,  32'h0,         2,  int'(FW * FH)};
        vecs[4] = '{1'b0, 40, 32'h0,         32, 0};
        vecs[5] = '{1'b0, 5,  32'h11,        3,  0};
        vecs[6] = '{1'b0, 32, 32'h8000_0001, 30, 0};
        vecs[7] = '{1'b0, 1,  32'h1,         0,  0};
        fill_desc(32'h0);

        repeat (3) @(posedge clk_33m);
        #1;
        check("reset pe_rst", pe_rst, 1);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        check("reset fb_we", fb_we, 0);
        check("reset fb_x", fb_x, 0);
        check("reset fb_y", fb_y, 0);
        check("reset fb_palette", fb_palette, 0);
        check("reset desc_addr", desc_addr, 0);
        check("reset pe_width", pe_width, 0);
        check("reset pe_height", pe_height, 0);
        check("reset pe_frame_x", pe_frame_x, 0);
        rst = 1'b0;

        // Single known element, all pixels visible then with transparency
        desc_mem[0] = '{12'd0, 12'd0, 12'sd10, 12'sd20, 12'd4, 12'd3};
        pm_mode = 0;
        run_frame("one elem", 1'b0, 1, 1, 0, 1'b0, nw);
        check("one elem writes", nw, 12);
        check("one elem pe_frame_x", pe_frame_x, 10);
        check("one elem pe_frame_y", pe_frame_y, 20);
        check("one elem pe_width", pe_width, 4);
        check("one elem pe_height", pe_height, 3);
        check("one elem pe_sprite_x", pe_sprite_x, 0);
        check("one elem pe_sprite_y", pe_sprite_y, 0);
        pm_mode = 1;
        run_frame("one elem transparent", 1'b0, 1, 1, 0, 1'b0, nw);
        check("transparent writes", nw, 9);

        for (int i = 0; i < 8; i++) begin
            fill_desc(vecs[i].zmask);
            run_frame($sformatf("vec%0d", i), vecs[i].ce, vecs[i].cnt,
                      vecs[i].exp_starts, vecs[i].exp_clear, 1'b0, nw);
        end

        // Second frame_start while painting must be ignored
        fill_desc(32'h0);
        run_frame("restart ignored", 1'b0, 2, 2, 0, 1'b1, nw);

        // Reset in the middle of painting aborts the frame silently
        fill_desc(32'h0);
        d0 = n_done;
        @(posedge clk_33m); #1;
        frame_start = 1'b1; clear_en = 1'b0; elem_count = 6'd3;
        @(posedge clk_33m); #1;
        frame_start = 1'b0;
        c = 0;
        while (!(desc_addr == 5'd1 && !pe_rst) && c < 2000) begin @(posedge clk_33m); #1; c++; end
        check("abort paint reached", longint'(c >= 2000), 0);
        rst = 1'b1;
        @(posedge clk_33m); #1;
        check("abort fb_we", fb_we, 0);
        check("abort busy", busy, 0);
        check("abort pe_rst", pe_rst, 1);
        check("abort desc_addr", desc_addr, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk_33m);
        #1;
        check("abort no frame_done", n_done - d0, 0);
        run_frame("after abort", 1'b0, 3, 3, 0, 1'b0, nw);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
